// File: rtl/rx_sync_aligner.sv
// Two-lane receive block-lock stage: deserialises per-lane bit streams into
// GEN2/GEN3/GEN4 blocks, hunts header lock by bit slipping, forwards locked blocks.
module rx_sync_aligner #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic         enc_clk,
    input  logic         rst,
    input  logic         rx_bit_valid,
    input  logic         lane_0_rx_bit,
    input  logic         lane_1_rx_bit,
    input  logic [1:0]   gen_speed,
    output logic [131:0] lane_0_rx_enc,
    output logic [131:0] lane_1_rx_enc,
    output logic         lane_0_blk_valid,
    output logic         lane_1_blk_valid,
    output logic         sync_lock_0,
    output logic         sync_lock_1,
    output logic         enable_dec
);

    localparam int W = 132;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    logic [1:0]   gen_reg;
    logic         gen_change;
    logic [7:0]   blk_len;
    logic [7:0]   last_idx;
    logic [W-1:0] len_mask;
    logic [1:0]   rx_bit;
    logic [1:0]   lock_q;
    logic [1:0]   blk_valid_q;
    logic [W-1:0] enc_q [2];
    logic         enable_dec_reg;

    assign rx_bit     = {lane_1_rx_bit, lane_0_rx_bit};
    assign gen_change = (gen_speed != gen_reg);
    assign last_idx   = blk_len - 8'd1;

    // Block geometry follows the registered speed so a change only takes effect
    // after both lanes have been flushed back to HUNT.
    always_comb begin
        case (gen_reg)
            2'b00:   blk_len = 8'd8;
            2'b10:   blk_len = 8'd66;
            default: blk_len = 8'd132;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign len_mask[gi] = (8'(gi) < blk_len);
        end
    endgenerate

    always_ff @(posedge enc_clk or posedge rst) begin
        if (rst) begin
            gen_reg        <= 2'b00;
            enable_dec_reg <= 1'b0;
        end else begin
            gen_reg        <= gen_speed;
            enable_dec_reg <= lock_q[0] & lock_q[1];
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            state_t       state_reg, state_next;
            logic [7:0]   bit_cnt_reg;
            logic [3:0]   good_cnt_reg, bad_cnt_reg;
            logic         slip_reg;
            logic [W-1:0] asm_reg, asm_full;
            logic [W-1:0] enc_reg;
            logic         blk_valid_reg;
            logic         take_bit, blk_done, hdr_ok;
            logic [3:0]   good_inc, bad_inc;
            logic         hunt_lock, lock_loss, emit, lock;

            assign take_bit  = rx_bit_valid & ~slip_reg & ~gen_change;
            assign blk_done  = take_bit & (bit_cnt_reg == last_idx);
            assign good_inc  = (good_cnt_reg == 4'hF) ? 4'hF : good_cnt_reg + 4'd1;
            assign bad_inc   = (bad_cnt_reg == 4'hF) ? 4'hF : bad_cnt_reg + 4'd1;
            assign hunt_lock = hdr_ok & (good_inc >= 4'(LOCK_CNT));
            assign lock_loss = ~hdr_ok & (bad_inc >= 4'(LOSS_CNT));

            // Header is judged on the block including the bit arriving this cycle.
            always_comb begin
                asm_full              = asm_reg;
                asm_full[bit_cnt_reg] = rx_bit[gi];
                case (gen_reg)
                    2'b00:   hdr_ok = 1'b1;
                    2'b10:   hdr_ok = (asm_full[65:64] == 2'b01) || (asm_full[65:64] == 2'b10);
                    default: hdr_ok = (asm_full[131:128] == 4'b0101) || (asm_full[131:128] == 4'b1010);
                endcase
            end

            always_ff @(posedge enc_clk or posedge rst) begin
                if (rst) state_reg <= HUNT;
                else     state_reg <= state_next;
            end

            always_comb begin
                state_next = state_reg;
                if (gen_change) begin
                    state_next = HUNT;
                end else if (blk_done) begin
                    case (state_reg)
                        HUNT:    if (hunt_lock) state_next = LOCKED;
                        LOCKED:  if (lock_loss) state_next = HUNT;
                        default: state_next = HUNT;
                    endcase
                end
            end

            always_comb begin
                lock = (state_reg == LOCKED);
                emit = 1'b0;
                if (blk_done) begin
                    if (state_reg == HUNT) emit = hunt_lock;
                    else                   emit = ~lock_loss;
                end
            end

            always_ff @(posedge enc_clk or posedge rst) begin
                if (rst) begin
                    bit_cnt_reg   <= '0;
                    good_cnt_reg  <= '0;
                    bad_cnt_reg   <= '0;
                    slip_reg      <= 1'b0;
                    asm_reg       <= '0;
                    enc_reg       <= '0;
                    blk_valid_reg <= 1'b0;
                end else begin
                    blk_valid_reg <= emit;
                    if (emit) enc_reg <= asm_full & len_mask;
                    if (gen_change) begin
                        bit_cnt_reg  <= '0;
                        good_cnt_reg <= '0;
                        bad_cnt_reg  <= '0;
                        slip_reg     <= 1'b0;
                    end else if (rx_bit_valid) begin
                        if (slip_reg) begin
                            slip_reg <= 1'b0;
                        end else begin
                            asm_reg <= asm_full;
                            if (bit_cnt_reg == last_idx) begin
                                bit_cnt_reg <= '0;
                                if (state_reg == HUNT) begin
                                    if (hdr_ok) begin
                                        good_cnt_reg <= good_inc;
                                        if (hunt_lock) bad_cnt_reg <= '0;
                                    end else begin
                                        good_cnt_reg <= '0;
                                        slip_reg     <= 1'b1;
                                    end
                                end else if (hdr_ok) begin
                                    bad_cnt_reg <= '0;
                                end else if (lock_loss) begin
                                    good_cnt_reg <= '0;
                                    bad_cnt_reg  <= '0;
                                end else begin
                                    bad_cnt_reg <= bad_inc;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 8'd1;
                            end
                        end
                    end
                end
            end

            assign lock_q[gi]      = lock;
            assign blk_valid_q[gi] = blk_valid_reg;
            assign enc_q[gi]       = enc_reg;
        end
    endgenerate

    assign lane_0_rx_enc    = enc_q[0];
    assign lane_1_rx_enc    = enc_q[1];
    assign lane_0_blk_valid = blk_valid_q[0];
    assign lane_1_blk_valid = blk_valid_q[1];
    assign sync_lock_0      = lock_q[0];
    assign sync_lock_1      = lock_q[1];
    assign enable_dec       = enable_dec_reg;

endmodule

// File: tb/tb_rx_sync_aligner.sv
// Bench for rx_sync_aligner: block-level reference model compared every cycle,
// plus directed lock / slip / loss / reset / speed-change scenarios.
module tb_rx_sync_aligner;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic         enc_clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_bit_valid = 1'b0;
    logic         lane_0_rx_bit = 1'b0;
    logic         lane_1_rx_bit = 1'b0;
    logic [1:0]   gen_speed = 2'b01;
    logic [131:0] lane_0_rx_enc, lane_1_rx_enc;
    logic         lane_0_blk_valid, lane_1_blk_valid;
    logic         sync_lock_0, sync_lock_1, enable_dec;

    rx_sync_aligner #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .enc_clk(enc_clk), .rst(rst), .rx_bit_valid(rx_bit_valid),
        .lane_0_rx_bit(lane_0_rx_bit), .lane_1_rx_bit(lane_1_rx_bit),
        .gen_speed(gen_speed),
        .lane_0_rx_enc(lane_0_rx_enc), .lane_1_rx_enc(lane_1_rx_enc),
        .lane_0_blk_valid(lane_0_blk_valid), .lane_1_blk_valid(lane_1_blk_valid),
        .sync_lock_0(sync_lock_0), .sync_lock_1(sync_lock_1), .enable_dec(enable_dec)
    );

    always #5 enc_clk = ~enc_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (per-block rules) ----------------
    logic [1:0]   m_gen;
    int           m_fill [2];
    logic [131:0] m_blk  [2];
    logic [131:0] m_enc  [2];
    logic         m_bv   [2];
    logic         m_lock [2];
    logic         m_skip [2];
    int           m_good [2];
    int           m_bad  [2];
    logic         m_en;

    function automatic int blen(input logic [1:0] g);
        if (g == 2'b00) return 8;
        if (g == 2'b10) return 66;
        return 132;
    endfunction

    function automatic logic hdr_good(input logic [1:0] g, input logic [131:0] b);
        if (g == 2'b00) return 1'b1;
        if (g == 2'b10) return (b[65:64] == 2'b01) || (b[65:64] == 2'b10);
        return (b[131:128] == 4'b0101) || (b[131:128] == 4'b1010);
    endfunction

    function automatic logic [131:0] len_mask(input int len);
        logic [131:0] mk;
        mk = '0;
        for (int i = 0; i < len; i++) mk[i] = 1'b1;
        return mk;
    endfunction

    task automatic model_reset();
        m_gen = 2'b00;
        m_en  = 1'b0;
        for (int l = 0; l < 2; l++) begin
            m_fill[l] = 0; m_blk[l] = '0; m_enc[l] = '0; m_bv[l] = 1'b0;
            m_lock[l] = 1'b0; m_skip[l] = 1'b0; m_good[l] = 0; m_bad[l] = 0;
        end
    endtask

    task automatic model_block(input int l);
        int   len;
        logic ok;
        len = blen(m_gen);
        ok  = hdr_good(m_gen, m_blk[l]);
        if (!m_lock[l]) begin
            if (ok) begin
                m_good[l] = (m_good[l] < 15) ? m_good[l] + 1 : 15;
                if (m_good[l] >= LOCK_CNT) begin
                    m_lock[l] = 1'b1; m_bad[l] = 0;
                    m_enc[l] = m_blk[l] & len_mask(len); m_bv[l] = 1'b1;
                end
            end else begin
                m_good[l] = 0; m_skip[l] = 1'b1;
            end
        end else if (ok) begin
            m_bad[l] = 0;
            m_enc[l] = m_blk[l] & len_mask(len); m_bv[l] = 1'b1;
        end else begin
            m_bad[l] = (m_bad[l] < 15) ? m_bad[l] + 1 : 15;
            if (m_bad[l] >= LOSS_CNT) begin
                m_lock[l] = 1'b0; m_good[l] = 0;
            end else begin
                m_enc[l] = m_blk[l] & len_mask(len); m_bv[l] = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        logic       en_next, gc;
        logic [1:0] bits;
        en_next = m_lock[0] & m_lock[1];
        gc      = (gen_speed != m_gen);
        bits    = {lane_1_rx_bit, lane_0_rx_bit};
        for (int l = 0; l < 2; l++) begin
            m_bv[l] = 1'b0;
            if (gc) begin
                m_fill[l] = 0; m_good[l] = 0; m_bad[l] = 0; m_skip[l] = 1'b0; m_lock[l] = 1'b0;
            end else if (rx_bit_valid) begin
                if (m_skip[l]) begin
                    m_skip[l] = 1'b0;
                end else begin
                    m_blk[l][m_fill[l]] = bits[l];
                    m_fill[l]++;
                    if (m_fill[l] == blen(m_gen)) begin
                        m_fill[l] = 0;
                        model_block(l);
                    end
                end
            end
        end
        m_en  = en_next;
        m_gen = gen_speed;
    endtask

    always @(posedge enc_clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge enc_clk) begin
        if (chk_en) begin
            chk("enc0", lane_0_rx_enc, m_enc[0]);
            chk("enc1", lane_1_rx_enc, m_enc[1]);
            chk1("blk_valid0", lane_0_blk_valid, m_bv[0]);
            chk1("blk_valid1", lane_1_blk_valid, m_bv[1]);
            chk1("sync_lock0", sync_lock_0, m_lock[0]);
            chk1("sync_lock1", sync_lock_1, m_lock[1]);
            chk1("enable_dec", enable_dec, m_en);
        end
    end

    // ---------------- stimulus ----------------
    bit           sq0 [$];
    bit           sq1 [$];
    logic [131:0] b0s [16];
    logic [131:0] b1s [16];
    int           bv0_cnt, bv1_cnt;

    task automatic cyc(input logic v, input logic x0, input logic x1);
        rx_bit_valid  = v;
        lane_0_rx_bit = x0;
        lane_1_rx_bit = x1;
        @(negedge enc_clk);
        #1;
        if (lane_0_blk_valid) bv0_cnt++;
        if (lane_1_blk_valid) bv1_cnt++;
    endtask

    task automatic run_bits(input int n, input int pct);
        int  sent;
        bit  x0, x1;
        sent = 0;
        while (sent < n) begin
            if ($urandom_range(0, 99) < pct) begin
                x0 = (sq0.size() > 0) ? sq0.pop_front() : 1'b0;
                x1 = (sq1.size() > 0) ? sq1.pop_front() : 1'b0;
                cyc(1'b1, x0, x1);
                sent++;
            end else begin
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic push_blk(input int lane, input logic [131:0] b, input int len);
        for (int i = 0; i < len; i++) begin
            if (lane == 0) sq0.push_back(b[i]);
            else           sq1.push_back(b[i]);
        end
    endtask

    function automatic logic [131:0] mk_blk(input int len, input logic [3:0] hdr, input bit ones);
        logic [131:0] d;
        d = '0;
        for (int i = 0; i < len; i++) d[i] = ones ? 1'b1 : 1'($urandom_range(0, 1));
        if (len == 132) d[131:128] = hdr;
        else if (len == 66) d[65:64] = hdr[1:0];
        return d;
    endfunction

    task automatic do_reset(input logic [1:0] g);
        gen_speed = g;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sq0.delete();
        sq1.delete();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        bv0_cnt = 0;
        bv1_cnt = 0;
    endtask

    logic [3:0] hdr_seq [10];

    initial begin
        cyc(1'b0, 1'b0, 1'b0);
        chk_en = 1;

        // GEN3 aligned lock
        do_reset(2'b01);
        chk1("reset_lock0", sync_lock_0, 1'b0);
        chk("reset_enc0", lane_0_rx_enc, 132'd0);
        for (int k = 0; k < 6; k++) begin
            b0s[k] = mk_blk(132, (k % 2) ? 4'b0101 : 4'b1010, 0);
            b1s[k] = mk_blk(132, (k % 2) ? 4'b1010 : 4'b0101, 0);
            push_blk(0, b0s[k], 132);
            push_blk(1, b1s[k], 132);
        end
        run_bits(3 * 132, 100);
        chk1("g3_no_lock_3blk", sync_lock_0, 1'b0);
        chk1("g3_no_bv_hunt", 1'(bv0_cnt != 0), 1'b0);
        run_bits(132, 100);
        chk1("g3_lock0", sync_lock_0, 1'b1);
        chk1("g3_lock1", sync_lock_1, 1'b1);
        chk1("g3_en_lag", enable_dec, 1'b0);
        chk("g3_hdr", {128'd0, lane_0_rx_enc[131:128]}, 132'h5);
        chk("g3_enc0", lane_0_rx_enc, b0s[3]);
        chk1("model_lock_pin", m_lock[0], 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk1("g3_en", enable_dec, 1'b1);

        // GEN2 with lane 1 offset by three junk bits
        do_reset(2'b10);
        push_blk(1, 132'd0, 3);
        for (int k = 0; k < 8; k++) begin
            push_blk(0, mk_blk(66, 4'b0001, 1), 66);
            push_blk(1, mk_blk(66, 4'b0001, 1), 66);
        end
        run_bits(4 * 66, 100);
        chk1("g2_lock0", sync_lock_0, 1'b1);
        chk1("g2_lock1_hunt", sync_lock_1, 1'b0);
        chk("g2_no_bv1_hunt", 132'(bv1_cnt), 132'd0);
        run_bits(464 - 4 * 66, 100);
        chk1("g2_lock1_not_yet", sync_lock_1, 1'b0);
        chk1("g2_en_not_yet", enable_dec, 1'b0);
        run_bits(1, 100);
        chk1("g2_lock1", sync_lock_1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk1("g2_en", enable_dec, 1'b1);

        // GEN3 bad-header tolerance and loss of lock
        do_reset(2'b01);
        hdr_seq = '{4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b0000,
                    4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
        for (int k = 0; k < 10; k++) begin
            b0s[k] = mk_blk(132, hdr_seq[k], 0);
            b1s[k] = mk_blk(132, hdr_seq[k], 0);
            push_blk(0, b0s[k], 132);
            push_blk(1, b1s[k], 132);
        end
        run_bits(6 * 132, 100);
        chk1("loss_hold_2bad", sync_lock_0, 1'b1);
        chk("loss_bad_out", lane_0_rx_enc, b0s[5]);
        run_bits(132, 100);
        chk1("loss_good_hold", sync_lock_0, 1'b1);
        run_bits(2 * 132, 100);
        chk1("loss_hold_again", sync_lock_0, 1'b1);
        chk("loss_enc_b8", lane_0_rx_enc, b0s[8]);
        run_bits(132, 100);
        chk1("loss_lock0", sync_lock_0, 1'b0);
        chk1("loss_lock1", sync_lock_1, 1'b0);
        chk1("loss_no_bv", lane_0_blk_valid, 1'b0);
        chk("loss_enc_held", lane_0_rx_enc, b0s[8]);
        chk1("loss_en_lag", enable_dec, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk1("loss_en_fall", enable_dec, 1'b0);

        // GEN4 repeated bytes
        do_reset(2'b00);
        for (int k = 0; k < 5; k++) begin
            push_blk(0, 132'hA5, 8);
            push_blk(1, 132'h3C, 8);
        end
        run_bits(24, 100);
        chk1("g4_no_lock", sync_lock_0, 1'b0);
        run_bits(8, 100);
        chk1("g4_lock", sync_lock_0, 1'b1);
        chk("g4_enc0", lane_0_rx_enc, 132'hA5);
        chk("g4_enc1", lane_1_rx_enc, 132'h3C);

        // GEN2 with gappy rx_bit_valid
        do_reset(2'b10);
        for (int k = 0; k < 6; k++) begin
            b0s[k] = mk_blk(66, (k % 2) ? 4'b0001 : 4'b0010, 0);
            b1s[k] = mk_blk(66, (k % 2) ? 4'b0010 : 4'b0001, 0);
            push_blk(0, b0s[k], 66);
            push_blk(1, b1s[k], 66);
        end
        run_bits(6 * 66, 50);
        chk("gap_enc0", lane_0_rx_enc, b0s[5]);
        chk("gap_enc1", lane_1_rx_enc, b1s[5]);
        chk("gap_bv_count", 132'(bv0_cnt), 132'd3);

        // Mid-block reset, relock, then speed change while locked
        do_reset(2'b01);
        for (int k = 0; k < 6; k++) begin
            push_blk(0, mk_blk(132, 4'b1010, 0), 132);
            push_blk(1, mk_blk(132, 4'b0101, 0), 132);
        end
        run_bits(4 * 132 + 60, 100);
        chk1("rst_pre_lock", sync_lock_0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_enc0", lane_0_rx_enc, 132'd0);
        chk("rst_enc1", lane_1_rx_enc, 132'd0);
        chk1("rst_lock0", sync_lock_0, 1'b0);
        chk1("rst_en", enable_dec, 1'b0);
        do_reset(2'b01);
        for (int k = 0; k < 5; k++) begin
            b0s[k] = mk_blk(132, 4'b0101, 0);
            push_blk(0, b0s[k], 132);
            push_blk(1, mk_blk(132, 4'b1010, 0), 132);
        end
        run_bits(5 * 132, 100);
        chk("relock_enc0", lane_0_rx_enc, b0s[4]);
        cyc(1'b0, 1'b0, 1'b0);
        gen_speed = 2'b10;
        cyc(1'b0, 1'b0, 1'b0);
        chk1("gchg_lock0", sync_lock_0, 1'b0);
        chk1("gchg_lock1", sync_lock_1, 1'b0);
        chk("gchg_enc_held", lane_0_rx_enc, b0s[4]);
        chk1("gchg_en_lag", enable_dec, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk1("gchg_en_fall", enable_dec, 1'b0);
        bv0_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            push_blk(0, mk_blk(66, 4'b0001, 0), 66);
            push_blk(1, mk_blk(66, 4'b0010, 0), 66);
        end
        run_bits(2 * 66, 100);
        chk("gchg_no_bv", 132'(bv0_cnt), 132'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
